// File: rtl/iob_merge_arbiter.sv
// Round-robin arbiter sharing one IOb-native subordinate port among N IOb managers.
// One transaction in flight; the grant is held until the write is accepted or the read data returns.
module iob_merge_arbiter #(
    parameter int unsigned N      = 2,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    localparam int unsigned NBITS  = ($clog2(N) == 0) ? 1 : $clog2(N),
    localparam int unsigned STRB_W = DATA_W / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cke_i,
    input  logic [N-1:0]          avalid_i,
    input  logic [N*ADDR_W-1:0]   addr_i,
    input  logic [N*DATA_W-1:0]   wdata_i,
    input  logic [N*STRB_W-1:0]   wstrb_i,
    output logic [N-1:0]          ready_o,
    output logic [N*DATA_W-1:0]   rdata_o,
    output logic [N-1:0]          rvalid_o,
    output logic                  avalid_o,
    output logic [ADDR_W-1:0]     addr_o,
    output logic [DATA_W-1:0]     wdata_o,
    output logic [STRB_W-1:0]     wstrb_o,
    input  logic                  ready_i,
    input  logic [DATA_W-1:0]     rdata_i,
    input  logic                  rvalid_i,
    output logic [NBITS-1:0]      grant_o,
    output logic                  busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_RD_WAIT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [NBITS-1:0]   grant_q, grant_d;
    logic [NBITS-1:0]   ptr_q, ptr_d;
    logic [NBITS-1:0]   pick;
    logic [NBITS-1:0]   grant_inc;

    logic [ADDR_W-1:0]  addr_arr  [N];
    logic [DATA_W-1:0]  wdata_arr [N];
    logic [STRB_W-1:0]  wstrb_arr [N];

    // Unpack the flat manager buses into per-manager slices.
    always_comb begin
        for (int unsigned k = 0; k < N; k++) begin
            addr_arr[k]  = addr_i[k*ADDR_W +: ADDR_W];
            wdata_arr[k] = wdata_i[k*DATA_W +: DATA_W];
            wstrb_arr[k] = wstrb_i[k*STRB_W +: STRB_W];
        end
    end

    // First requester at or above ptr wins; otherwise wrap to the lowest requester.
    always_comb begin
        logic             hi_found;
        logic [NBITS-1:0] hi_idx;
        logic [NBITS-1:0] lo_idx;
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int k = int'(N) - 1; k >= 0; k--) begin
            if (avalid_i[k]) begin
                if (k >= int'(ptr_q)) begin
                    hi_found = 1'b1;
                    hi_idx   = NBITS'(k);
                end
                lo_idx = NBITS'(k);
            end
        end
        pick = hi_found ? hi_idx : lo_idx;
    end

    assign grant_inc = (grant_q == NBITS'(N - 1)) ? '0 : grant_q + NBITS'(1);

    // Next-state and port steering.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        ptr_d    = ptr_q;
        avalid_o = 1'b0;
        ready_o  = '0;
        rvalid_o = '0;
        addr_o   = addr_arr[grant_q];
        wdata_o  = wdata_arr[grant_q];
        wstrb_o  = wstrb_arr[grant_q];

        case (state_q)
            ST_IDLE: begin
                if (|avalid_i) begin
                    grant_d = pick;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                avalid_o         = avalid_i[grant_q];
                ready_o[grant_q] = ready_i;
                if (avalid_i[grant_q] && ready_i) begin
                    if (|wstrb_arr[grant_q]) begin
                        state_d = ST_IDLE;
                        ptr_d   = grant_inc;
                    end else begin
                        state_d = ST_RD_WAIT;
                    end
                end else if (!avalid_i[grant_q]) begin
                    // Manager withdrew before acceptance: release the port.
                    state_d = ST_IDLE;
                    ptr_d   = grant_inc;
                end
            end
            ST_RD_WAIT: begin
                rvalid_o[grant_q] = rvalid_i;
                if (rvalid_i) begin
                    state_d = ST_IDLE;
                    ptr_d   = grant_inc;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign rdata_o = {N{rdata_i}};
    assign grant_o = grant_q;
    assign busy_o  = (state_q != ST_IDLE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
        end else if (cke_i) begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

endmodule

// File: tb/tb_iob_merge_arbiter.sv
// Bench for iob_merge_arbiter (N=4): directed scenarios plus randomized batches
// checked by a queue-based scoreboard against a round-robin service-order model.
module tb_iob_merge_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;
    localparam logic [31:0] KEY = 32'h5A5A_A5A5;

    logic              clk = 1'b0;
    logic              rst_i, cke_i;
    logic [N-1:0]      avalid_i;
    logic [N*AW-1:0]   addr_i;
    logic [N*DW-1:0]   wdata_i;
    logic [N*SW-1:0]   wstrb_i;
    logic [N-1:0]      ready_o;
    logic [N*DW-1:0]   rdata_o;
    logic [N-1:0]      rvalid_o;
    logic              avalid_o;
    logic [AW-1:0]     addr_o;
    logic [DW-1:0]     wdata_o;
    logic [SW-1:0]     wstrb_o;
    logic              ready_i;
    logic [DW-1:0]     rdata_i;
    logic              rvalid_i;
    logic [1:0]        grant_o;
    logic              busy_o;

    logic [N-1:0]      m_avalid;
    logic [AW-1:0]     m_addr  [N];
    logic [DW-1:0]     m_wdata [N];
    logic [SW-1:0]     m_wstrb [N];

    always #5 clk = ~clk;

    iob_merge_arbiter #(.N(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_i(clk), .rst_i(rst_i), .cke_i(cke_i),
        .avalid_i(avalid_i), .addr_i(addr_i), .wdata_i(wdata_i), .wstrb_i(wstrb_i),
        .ready_o(ready_o), .rdata_o(rdata_o), .rvalid_o(rvalid_o),
        .avalid_o(avalid_o), .addr_o(addr_o), .wdata_o(wdata_o), .wstrb_o(wstrb_o),
        .ready_i(ready_i), .rdata_i(rdata_i), .rvalid_i(rvalid_i),
        .grant_o(grant_o), .busy_o(busy_o)
    );

    always_comb begin
        avalid_i = m_avalid;
        for (int k = 0; k < N; k++) begin
            addr_i[k*AW +: AW]  = m_addr[k];
            wdata_i[k*DW +: DW] = m_wdata[k];
            wstrb_i[k*SW +: SW] = m_wstrb[k];
        end
    end

    typedef struct {
        string       nm;
        logic        av;
        logic        bz;
        int          g;
        logic [3:0]  rdy;
        logic [3:0]  rv;
        logic        ca;
        logic [31:0] a;
        logic        cr;
        logic [31:0] rd;
    } snap_t;

    typedef struct {
        int          mgr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    typedef struct {
        int          mgr;
        logic [31:0] data;
    } rsp_t;

    snap_t snap_q [$];
    req_t  exp_req [$];
    rsp_t  exp_rsp [$];

    int          checks = 0;
    int          fails  = 0;
    int          cyc    = 0;
    logic        sb_en  = 1'b0;
    logic        fin    = 1'b0;
    logic        abort  = 1'b0;
    logic [3:0]  acc_mask = '0;
    logic        rd_pending = 1'b0;
    int          rd_due = 0;
    logic [31:0] rd_data = '0;
    int          stall = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [3:0] oh(input int g);
        logic [3:0] r;
        r = '0;
        r[g] = 1'b1;
        return r;
    endfunction

    function automatic void cmp(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, req, $time);
        end
    endfunction

    // Monitor: directed snapshots, scoreboard pops and per-cycle invariants.
    always @(negedge clk) begin : mon
        snap_t s;
        req_t  r;
        rsp_t  p;
        logic  progress;
        progress = 1'b0;
        acc_mask = '0;

        if (snap_q.size() > 0) begin
            s = snap_q.pop_front();
            cmp({s.nm, ".avalid"}, 64'(avalid_o), 64'(s.av));
            cmp({s.nm, ".busy"},   64'(busy_o),   64'(s.bz));
            cmp({s.nm, ".ready"},  64'(ready_o),  64'(s.rdy));
            cmp({s.nm, ".rvalid"}, 64'(rvalid_o), 64'(s.rv));
            if (s.g >= 0) cmp({s.nm, ".grant"}, 64'(grant_o), 64'(s.g));
            if (s.ca)     cmp({s.nm, ".addr"},  64'(addr_o),  64'(s.a));
            if (s.cr)     cmp({s.nm, ".rdata2"}, 64'(rdata_o[2*DW +: DW]), 64'(s.rd));
        end

        cmp("ready_onehot",  64'($countones(ready_o) <= 1),  64'(1));
        cmp("rvalid_onehot", 64'($countones(rvalid_o) <= 1), 64'(1));

        if (sb_en && cke_i && !rst_i) begin
            if (avalid_o && ready_i) begin
                progress = 1'b1;
                acc_mask = oh(int'(grant_o));
                if (exp_req.size() == 0) begin
                    checks++; fails++;
                    $display("FAIL sb_unexpected_req: got grant %0d addr 0x%0h expected none", grant_o, addr_o);
                end else begin
                    r = exp_req.pop_front();
                    cmp("sb_grant", 64'(grant_o), 64'(r.mgr));
                    cmp("sb_addr",  64'(addr_o),  64'(r.addr));
                    cmp("sb_wstrb", 64'(wstrb_o), 64'(r.wstrb));
                    if (r.wstrb != 0) cmp("sb_wdata", 64'(wdata_o), 64'(r.wdata));
                    cmp("sb_ready_o", 64'(ready_o), 64'(oh(r.mgr)));
                end
                if (wstrb_o == '0) begin
                    rd_pending = 1'b1;
                    rd_due     = cyc + int'($urandom_range(0, 4));
                    rd_data    = addr_o ^ KEY;
                end
            end
            if (rvalid_o != '0) begin
                progress   = 1'b1;
                rd_pending = 1'b0;
                if (exp_rsp.size() == 0) begin
                    checks++; fails++;
                    $display("FAIL sb_unexpected_rvalid: got rvalid_o 0x%0h expected none", rvalid_o);
                end else begin
                    p = exp_rsp.pop_front();
                    cmp("sb_rvalid_o", 64'(rvalid_o), 64'(oh(p.mgr)));
                    cmp("sb_rdata",    64'(rdata_o[p.mgr*DW +: DW]), 64'(p.data));
                end
            end
            if (progress || (exp_req.size() == 0 && exp_rsp.size() == 0)) stall = 0;
            else stall++;
            if (stall > 400 && !abort) begin
                checks++; fails++;
                $display("FAIL sb_timeout: got no progress for %0d cycles expected completion", stall);
                abort = 1'b1;
            end
        end

        if (fin) cmp("sb_drained", 64'(exp_req.size() + exp_rsp.size()), 64'(0));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expc(input string nm, input logic av, input logic bz, input int g,
                        input logic [3:0] rdy, input logic [3:0] rv,
                        input logic ca = 1'b0, input logic [31:0] a = '0,
                        input logic cr = 1'b0, input logic [31:0] rd = '0);
        snap_t s;
        s.nm = nm; s.av = av; s.bz = bz; s.g = g; s.rdy = rdy; s.rv = rv;
        s.ca = ca; s.a = a; s.cr = cr; s.rd = rd;
        snap_q.push_back(s);
        @(negedge clk);
        #1;
    endtask

    task automatic e_idle(input string nm);
        expc(nm, 1'b0, 1'b0, -1, 4'b0, 4'b0);
    endtask

    task automatic e_req(input string nm, input int g, input logic [3:0] rdy, input logic [31:0] a);
        expc(nm, 1'b1, 1'b1, g, rdy, 4'b0, 1'b1, a);
    endtask

    initial begin
        int mptr, last, guard;
        logic [3:0] mask;

        rst_i = 1'b1; cke_i = 1'b1; ready_i = 1'b0; rvalid_i = 1'b0; rdata_i = '0;
        m_avalid = '0;
        for (int k = 0; k < N; k++) begin
            m_addr[k] = 32'(k * 256); m_wdata[k] = 32'(k) + 32'h1000; m_wstrb[k] = 4'hF;
        end

        // Reset held for two cycles.
        step(); expc("rst1", 1'b0, 1'b0, 0, 4'b0, 4'b0);
        step(); expc("rst2", 1'b0, 1'b0, 0, 4'b0, 4'b0);
        step(); rst_i = 1'b0;

        // All four managers writing, subordinate always ready: 0,1,2,3,0 with idle gaps.
        m_avalid = 4'hF; ready_i = 1'b1;
        e_idle("rr_arb");
        for (int c = 0; c < 9; c++) begin
            step();
            if (c % 2 == 0) e_req($sformatf("rr_c%0d", c), (c / 2) % 4, oh((c / 2) % 4), 32'((c / 2) % 4 * 256));
            else            e_idle($sformatf("rr_c%0d", c));
        end
        step(); m_avalid = '0; ready_i = 1'b0;

        // Manager 2 read; manager 1 requests during the read and must wait.
        step(); m_avalid = 4'b0100; m_wstrb[2] = 4'h0; m_addr[2] = 32'h40;
        e_idle("rd_arb");
        step(); m_avalid[1] = 1'b1;
        e_req("rd_req", 2, 4'b0000, 32'h40);
        step(); ready_i = 1'b1;
        e_req("rd_acc", 2, 4'b0100, 32'h40);
        step(); ready_i = 1'b0; m_avalid[2] = 1'b0;
        expc("rd_wait1", 1'b0, 1'b1, 2, 4'b0, 4'b0);
        step(); expc("rd_wait2", 1'b0, 1'b1, 2, 4'b0, 4'b0);
        step(); rvalid_i = 1'b1; rdata_i = 32'hDEAD_BEEF;
        expc("rd_data", 1'b0, 1'b1, 2, 4'b0, 4'b0100, 1'b0, '0, 1'b1, 32'hDEAD_BEEF);
        step(); rvalid_i = 1'b0;
        e_idle("rd_done");
        step(); ready_i = 1'b1;
        e_req("m1_after_rd", 1, 4'b0010, 32'h100);
        step(); m_avalid = '0; ready_i = 1'b0;

        // Stalled subordinate: request and address must hold while ready_i is low.
        step(); m_avalid = 4'b1001; m_addr[0] = 32'hAA; m_addr[3] = 32'h333;
        m_wstrb[0] = 4'hF; m_wstrb[3] = 4'h3;
        e_idle("stall_arb");
        for (int i = 0; i < 5; i++) begin
            step(); e_req($sformatf("stall_%0d", i), 3, 4'b0000, 32'h333);
        end
        step(); ready_i = 1'b1;
        e_req("stall_acc", 3, 4'b1000, 32'h333);
        step(); m_avalid[3] = 1'b0; ready_i = 1'b0;
        e_idle("stall_done");
        step(); e_req("m0_req", 0, 4'b0000, 32'hAA);

        // Clock enable low for three edges while ready_i is high.
        step(); cke_i = 1'b0; ready_i = 1'b1;
        e_req("cke_0", 0, 4'b0001, 32'hAA);
        for (int i = 1; i < 3; i++) begin
            step(); e_req($sformatf("cke_%0d", i), 0, 4'b0001, 32'hAA);
        end
        step(); cke_i = 1'b1;
        e_req("cke_resume", 0, 4'b0001, 32'hAA);
        step(); m_avalid = '0; ready_i = 1'b0;
        e_idle("cke_done");

        // Reset in RD_WAIT, late rvalid ignored, pointer back at 0.
        step(); m_avalid = 4'b0010; m_wstrb[1] = 4'h0; m_addr[1] = 32'h11; ready_i = 1'b1;
        e_idle("rst_arb");
        step(); e_req("rst_req", 1, 4'b0010, 32'h11);
        step(); m_avalid = '0; ready_i = 1'b0;
        expc("rst_rdwait", 1'b0, 1'b1, 1, 4'b0, 4'b0);
        step(); rst_i = 1'b1;
        expc("rst_pre", 1'b0, 1'b1, 1, 4'b0, 4'b0);
        step(); rst_i = 1'b0; rvalid_i = 1'b1; rdata_i = 32'h1234_5678;
        expc("rst_late_rvalid", 1'b0, 1'b0, 0, 4'b0, 4'b0);
        step(); rvalid_i = 1'b0; m_avalid = 4'b0101; m_wstrb[0] = 4'hF; m_wstrb[2] = 4'hF;
        e_idle("ptr0_arb");
        step(); e_req("ptr0_grant", 0, 4'b0000, 32'hAA);
        step(); m_avalid = '0;
        expc("withdraw", 1'b0, 1'b1, 0, 4'b0, 4'b0);
        step(); e_idle("withdraw_idle");
        step(); m_avalid = 4'b0011; m_wstrb[1] = 4'hF;
        e_idle("ptr1_arb");
        step(); e_req("ptr1_grant", 1, 4'b0000, 32'h11);
        step(); m_avalid = '0;

        // Randomized batches against the round-robin service-order model.
        rst_i = 1'b1;
        step(); step(); rst_i = 1'b0;
        sb_en = 1'b1;
        mptr  = 0;
        for (int b = 0; b < 80 && !abort; b++) begin
            step();
            mask = 4'($urandom_range(1, 15));
            for (int k = 0; k < N; k++) begin
                if (mask[k]) begin
                    m_addr[k]  = $urandom;
                    m_wdata[k] = $urandom;
                    m_wstrb[k] = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
                end
            end
            last = 0;
            for (int i = 0; i < N; i++) begin
                int k;
                k = (mptr + i) % N;
                if (mask[k]) begin
                    exp_req.push_back('{mgr: k, addr: m_addr[k], wdata: m_wdata[k], wstrb: m_wstrb[k]});
                    if (m_wstrb[k] == 4'h0) exp_rsp.push_back('{mgr: k, data: m_addr[k] ^ KEY});
                    last = k;
                end
            end
            mptr = (last + 1) % N;
            m_avalid = mask;
            guard = 0;
            while ((m_avalid != '0 || rd_pending || exp_req.size() != 0 || exp_rsp.size() != 0)
                   && !abort && guard < 2000) begin
                step();
                guard++;
                m_avalid = m_avalid & ~acc_mask;
                ready_i  = 1'($urandom_range(0, 1));
                cke_i    = ($urandom_range(0, 9) != 0);
                if (rd_pending) begin
                    rvalid_i = (cyc >= rd_due);
                    rdata_i  = rd_data;
                end else begin
                    rvalid_i = ($urandom_range(0, 7) == 0);
                    rdata_i  = $urandom;
                end
            end
        end

        step();
        cke_i = 1'b1; rvalid_i = 1'b0; ready_i = 1'b0; m_avalid = '0;
        fin = 1'b1;
        @(negedge clk);
        #1;
        fin = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
